// File: rtl/jedro_1_dmem_arbiter.sv
// jedro_1_dmem_arbiter: round-robin arbiter sharing the single-port data RAM
// between the load-store unit (requester 0) and a second bus master
// (requester 1). The RAM request is registered. A {valid, owner} pipeline
// sends each read response back to the requester that issued it.
module jedro_1_dmem_arbiter #(
    parameter int DATA_WIDTH       = 32,
    parameter int ADDR_WIDTH       = 32,
    parameter int RAM_READ_LATENCY = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    // requester 0
    input  logic                    req_0_i,
    input  logic [DATA_WIDTH/8-1:0] we_0_i,
    input  logic [ADDR_WIDTH-1:0]   addr_0_i,
    input  logic [DATA_WIDTH-1:0]   wdata_0_i,
    output logic                    gnt_0_o,
    output logic                    rvalid_0_o,
    output logic [DATA_WIDTH-1:0]   rdata_0_o,
    // requester 1
    input  logic                    req_1_i,
    input  logic [DATA_WIDTH/8-1:0] we_1_i,
    input  logic [ADDR_WIDTH-1:0]   addr_1_i,
    input  logic [DATA_WIDTH-1:0]   wdata_1_i,
    output logic                    gnt_1_o,
    output logic                    rvalid_1_o,
    output logic [DATA_WIDTH-1:0]   rdata_1_o,
    // RAM side
    output logic                    ram_stb_o,
    output logic [DATA_WIDTH/8-1:0] ram_we_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    localparam int BE_W = DATA_WIDTH / 8;
    localparam int LAT  = RAM_READ_LATENCY;

    // Round-robin pointer: the requester favoured under contention.
    logic                  r_ptr;

    logic                  w_gnt_0;
    logic                  w_gnt_1;
    logic                  w_gnt;
    logic                  w_id;
    logic                  w_rd;
    logic [BE_W-1:0]       w_we;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [DATA_WIDTH-1:0] w_wdata;

    // Stage i of the response pipeline holds {valid, owner}. The last stage
    // lines up with the cycle in which ram_rdata_i is valid.
    logic [LAT:0]          r_vld_pipe;
    logic [LAT:0]          r_own_pipe;

    // Grant decision and winner mux. This is purely a function of the
    // requests, the pointer and reset, so RAM read data cannot reach it.
    always_comb begin
        w_gnt_0 = !rst_i && req_0_i && (!req_1_i || !r_ptr);
        w_gnt_1 = !rst_i && req_1_i && (!req_0_i ||  r_ptr);
        w_gnt   = w_gnt_0 || w_gnt_1;
        w_id    = w_gnt_1;
        w_we    = w_id ? we_1_i    : we_0_i;
        w_addr  = w_id ? addr_1_i  : addr_0_i;
        w_wdata = w_id ? wdata_1_i : wdata_0_i;
        w_rd    = w_gnt && (w_we == '0);
    end

    assign gnt_0_o = w_gnt_0;
    assign gnt_1_o = w_gnt_1;

    // Pointer moves to the other requester after every grant and holds when idle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)        r_ptr <= 1'b0;
        else if (w_gnt_0) r_ptr <= 1'b1;
        else if (w_gnt_1) r_ptr <= 1'b0;
    end

    // Register the winning access. Address and data hold when idle, so the
    // RAM pins only toggle on real accesses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ram_stb_o   <= 1'b0;
            ram_we_o    <= '0;
            ram_addr_o  <= '0;
            ram_wdata_o <= '0;
        end else begin
            ram_stb_o <= w_gnt;
            ram_we_o  <= w_gnt ? w_we : '0;
            if (w_gnt) begin
                ram_addr_o  <= w_addr;
                ram_wdata_o <= w_wdata;
            end
        end
    end

    // Read tracking shift register. Reset wipes any reads still in flight.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_vld_pipe <= '0;
            r_own_pipe <= '0;
        end else begin
            r_vld_pipe <= {r_vld_pipe[LAT-1:0], w_rd};
            r_own_pipe <= {r_own_pipe[LAT-1:0], w_id};
        end
    end

    // Route the returning word to its owner. The idle requester sees zero data.
    always_comb begin
        rvalid_0_o = r_vld_pipe[LAT] && !r_own_pipe[LAT];
        rvalid_1_o = r_vld_pipe[LAT] &&  r_own_pipe[LAT];
        rdata_0_o  = rvalid_0_o ? ram_rdata_i : '0;
        rdata_1_o  = rvalid_1_o ? ram_rdata_i : '0;
    end

endmodule

// File: tb/tb_jedro_1_dmem_arbiter.sv
// Self-checking bench for jedro_1_dmem_arbiter. There are two instances:
// one at the default read latency with a scoreboard on its responses, and one
// at RAM_READ_LATENCY=3 with directed checks on its response timing.
module tb_jedro_1_dmem_arbiter;

    typedef struct {
        bit          owner;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    exp_t sb[$];

    // Bench's own view of RAM contents, updated from the stimulus side.
    logic [31:0] ref_mem [0:255];
    // RAM model contents, written through the DUT's ram_* pins.
    logic [31:0] mem     [0:255];

    // ---------------- latency-1 DUT ----------------
    logic        req0 = 0, req1 = 0;
    logic [3:0]  we0 = 0, we1 = 0;
    logic [31:0] addr0 = 0, addr1 = 0, wd0 = 0, wd1 = 0;
    logic        gnt0, gnt1, rv0, rv1, stb;
    logic [31:0] rd0, rd1, raddr, rwdata, rdata;
    logic [3:0]  rwe;

    jedro_1_dmem_arbiter dut (
        .clk_i(clk), .rst_i(rst),
        .req_0_i(req0), .we_0_i(we0), .addr_0_i(addr0), .wdata_0_i(wd0),
        .gnt_0_o(gnt0), .rvalid_0_o(rv0), .rdata_0_o(rd0),
        .req_1_i(req1), .we_1_i(we1), .addr_1_i(addr1), .wdata_1_i(wd1),
        .gnt_1_o(gnt1), .rvalid_1_o(rv1), .rdata_1_o(rd1),
        .ram_stb_o(stb), .ram_we_o(rwe), .ram_addr_o(raddr),
        .ram_wdata_o(rwdata), .ram_rdata_i(rdata)
    );

    // ---------------- latency-3 DUT ----------------
    logic        q0 = 0, q1 = 0;
    logic [31:0] a0 = 0, a1 = 0;
    logic        g0_3, g1_3, rv0_3, rv1_3, stb3;
    logic [31:0] rd0_3, rd1_3, raddr3, rwdata3, rdata3;
    logic [3:0]  rwe3;

    jedro_1_dmem_arbiter #(.RAM_READ_LATENCY(3)) dut3 (
        .clk_i(clk), .rst_i(rst),
        .req_0_i(q0), .we_0_i(4'b0), .addr_0_i(a0), .wdata_0_i(32'h0),
        .gnt_0_o(g0_3), .rvalid_0_o(rv0_3), .rdata_0_o(rd0_3),
        .req_1_i(q1), .we_1_i(4'b0), .addr_1_i(a1), .wdata_1_i(32'h0),
        .gnt_1_o(g1_3), .rvalid_1_o(rv1_3), .rdata_1_o(rd1_3),
        .ram_stb_o(stb3), .ram_we_o(rwe3), .ram_addr_o(raddr3),
        .ram_wdata_o(rwdata3), .ram_rdata_i(rdata3)
    );

    // RAM models: byte-masked write at the edge ending the strobe cycle.
    // Read data appears LAT cycles after the strobe cycle.
    logic [31:0] rp1;
    logic [31:0] rp3 [0:2];
    assign rdata  = rp1;
    assign rdata3 = rp3[2];

    always @(posedge clk) begin
        if (stb) begin
            for (int b = 0; b < 4; b++)
                if (rwe[b]) mem[raddr[9:2]][8*b +: 8] <= rwdata[8*b +: 8];
        end
        rp1    <= (stb && rwe == 4'b0) ? mem[raddr[9:2]] : 32'hDEAD_BEEF;
        rp3[0] <= (stb3 && rwe3 == 4'b0) ? mem[raddr3[9:2]] : 32'hDEAD_BEEF;
        rp3[1] <= rp3[0];
        rp3[2] <= rp3[1];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Response monitor for the latency-1 DUT: every rvalid must match the
    // oldest outstanding read in the scoreboard.
    always @(negedge clk) begin
        if (!rst && (rv0 || rv1)) begin
            exp_t e;
            chk("rvalid_exclusive", {63'b0, rv0 && rv1}, 64'd0);
            if (sb.size() == 0) begin
                chk("unexpected_rvalid", {62'b0, rv1, rv0}, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_owner", {63'b0, rv1}, {63'b0, e.owner});
                chk("resp_data", {32'b0, (rv1 ? rd1 : rd0)}, {32'b0, e.data});
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'hC0DE_0000 + i;
            ref_mem[i] = 32'hC0DE_0000 + i;
        end
        rp1 = 0;
        for (int i = 0; i < 3; i++) rp3[i] = 0;

        // Reset state: outputs clear and grant is suppressed even with a request present.
        req0 = 1; addr0 = 32'h100;
        #2;
        chk("rst_gnt0", {63'b0, gnt0}, 64'd0);
        chk("rst_stb", {63'b0, stb}, 64'd0);
        chk("rst_we_addr_wdata", {rwe, raddr, rwdata[27:0]}, 64'd0);
        chk("rst_rvalid_rdata", {rv0, rv1, rd0[30:0], rd1[30:0]}, 64'd0);

        // Reset mid-read: read 0x100 is accepted, then reset hits in T+1.
        step(); step();
        rst = 0;
        #1;
        chk("mr_gnt0", {63'b0, gnt0}, 64'd1);
        step();                              // T+1
        chk("mr_stb_t1", {31'b0, stb, raddr}, {31'b0, 1'b1, 32'h100});
        rst = 1;
        #1;
        chk("mr_async_clear", {27'b0, stb, rwe, raddr}, 64'd0);
        chk("mr_gnt_forced0", {62'b0, gnt0, gnt1}, 64'd0);
        step(); step();
        req0 = 0;
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("mr_no_rvalid", {62'b0, rv1, rv0}, 64'd0);
        end

        // Contention from reset (ptr=0): grants alternate 0,1,0,1.
        req0 = 1; addr0 = 32'h10; we0 = 0;
        req1 = 1; addr1 = 32'h20; we1 = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk("ct_gnt", {62'b0, gnt1, gnt0}, (c % 2 == 0) ? 64'd1 : 64'd2);
            if (c % 2 == 0) sb.push_back('{1'b0, ref_mem[8'h10 >> 2]});
            else            sb.push_back('{1'b1, ref_mem[8'h20 >> 2]});
            step();
            chk("ct_addr", {31'b0, stb, raddr}, {31'b0, 1'b1, (c % 2 == 0) ? 32'h10 : 32'h20});
        end
        req0 = 0; req1 = 0;
        step(); step(); step();

        // Single read by requester 0 from 0x40.
        req0 = 1; addr0 = 32'h40;
        #1;
        chk("sr_gnt", {62'b0, gnt1, gnt0}, 64'd1);
        sb.push_back('{1'b0, ref_mem[8'h40 >> 2]});
        step();                              // T+1
        req0 = 0;
        chk("sr_ram_t1", {27'b0, stb, rwe, raddr}, {27'b0, 1'b1, 4'b0, 32'h40});
        chk("sr_no_rvalid_t1", {62'b0, rv1, rv0}, 64'd0);
        step();                              // T+2
        chk("sr_rvalid_t2", {62'b0, rv1, rv0}, 64'd1);
        step();
        chk("sr_rdata_zero_idle", {32'b0, rd0}, 64'd0);

        // Write byte 2 by requester 1, then read it back.
        req1 = 1; we1 = 4'b0100; addr1 = 32'h8; wd1 = 32'h00AB_0000;
        #1;
        chk("wr_gnt", {62'b0, gnt1, gnt0}, 64'd2);
        ref_mem[2][23:16] = 8'hAB;
        step();                              // T+1: write on the RAM pins
        chk("wr_ram_t1", {27'b0, stb, rwe, raddr}, {27'b0, 1'b1, 4'b0100, 32'h8});
        chk("wr_wdata", {32'b0, rwdata}, {32'b0, 32'h00AB_0000});
        we1 = 4'b0; wd1 = 0;                 // read back of 0x8
        #1;
        chk("rb_gnt", {62'b0, gnt1, gnt0}, 64'd2);
        sb.push_back('{1'b1, ref_mem[2]});
        step();
        req1 = 0;
        chk("wr_no_rvalid", {62'b0, rv1, rv0}, 64'd0);
        step();
        chk("rb_rvalid1", {62'b0, rv1, rv0}, 64'd2);
        chk("rb_byte2", {56'b0, rd1[23:16]}, 64'hAB);
        step();
        // Idle: strobe and enables drop while address and data hold.
        chk("idle_hold", {27'b0, stb, rwe, raddr}, {27'b0, 1'b0, 4'b0, 32'h8});

        // Latency 3 on dut3: reads from 0,1,0 back to back.
        q0 = 1; a0 = 32'h30;
        #1;
        chk("l3_gnt_t0", {62'b0, g1_3, g0_3}, 64'd1);
        step();
        q0 = 0; q1 = 1; a1 = 32'h34;
        #1;
        chk("l3_gnt_t1", {62'b0, g1_3, g0_3}, 64'd2);
        step();
        q0 = 1; q1 = 0; a0 = 32'h38;
        #1;
        chk("l3_gnt_t2", {62'b0, g1_3, g0_3}, 64'd1);
        step();                              // T+3
        q0 = 0;
        chk("l3_none_t3", {62'b0, rv1_3, rv0_3}, 64'd0);
        step();                              // T+4
        chk("l3_rv_t4", {30'b0, rv1_3, rv0_3, rd0_3}, {30'b0, 2'b01, ref_mem[12]});
        step();                              // T+5
        chk("l3_rv_t5", {30'b0, rv1_3, rv0_3, rd1_3}, {30'b0, 2'b10, ref_mem[13]});
        step();                              // T+6
        chk("l3_rv_t6", {30'b0, rv1_3, rv0_3, rd0_3}, {30'b0, 2'b01, ref_mem[14]});
        step();
        chk("l3_none_t7", {62'b0, rv1_3, rv0_3}, 64'd0);

        step(); step();
        chk("sb_drained", sb.size(), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
